// File: rtl/mpu_mul_seq_ctrl.sv
// Sequential 5x5 matrix multiply controller: one time-shared 8x8 MAC stepped by i/j/k loops.
// Define MPU_MUL_SAT_EN for saturating accumulation (default: wrap modulo 2^RW).
module mpu_mul_seq_ctrl #(
  parameter int N_MAX = 5,
  parameter int DW    = 8,
  parameter int RW    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [7:0]                   size,
  input  logic [0:DW*N_MAX*N_MAX-1]    matrix_a,
  input  logic [0:DW*N_MAX*N_MAX-1]    matrix_b,
  output logic                         busy,
  output logic                         done,
  output logic                         result_valid,
  output logic [RW*N_MAX*N_MAX-1:0]    result
);

  localparam int AW = DW*N_MAX*N_MAX;
  localparam int OW = RW*N_MAX*N_MAX;
  localparam int CW = $clog2(N_MAX+1);

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [0:AW-1]   a_q, b_q;
  logic [OW-1:0]   res_q;
  logic [RW-1:0]   acc_q, sum;
  logic [CW-1:0]   i_q, j_q, k_q, n_q, n_eff;
  logic [DW-1:0]   a_el, b_el;
  logic [2*DW-1:0] prod;
  logic            rv_q;
  logic            last_i, last_j, last_k;
  int              a_off, b_off, r_off;

  always_comb begin
    n_eff = size[CW-1:0];
    if (size == 8'd0 || size > 8'(N_MAX))
      n_eff = CW'(N_MAX);
  end

  always_comb begin
    a_off  = DW*(int'(k_q) + N_MAX*int'(i_q));
    b_off  = DW*(int'(j_q) + N_MAX*int'(k_q));
    r_off  = RW*(int'(j_q)*N_MAX + int'(i_q));
    a_el   = a_q[a_off +: DW];
    b_el   = b_q[b_off +: DW];
    prod   = (2*DW)'(a_el) * (2*DW)'(b_el);
    last_k = (k_q == n_q - 1'b1);
    last_j = (j_q == n_q - 1'b1);
    last_i = (i_q == n_q - 1'b1);
  end

`ifdef MPU_MUL_SAT_EN
  logic [RW:0] wide;
  // A saturated acc stays pinned: adding a nonnegative product re-saturates.
  always_comb begin
    wide = {1'b0, acc_q} + (RW+1)'(prod);
    sum  = wide[RW] ? '1 : wide[RW-1:0];
  end
`else
  always_comb begin
    sum = acc_q + RW'(prod);
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = MAC;
      MAC:  if (last_k && last_j && last_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      acc_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      k_q   <= '0;
      n_q   <= '0;
      rv_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_q   <= matrix_a;
            b_q   <= matrix_b;
            n_q   <= n_eff;
            res_q <= '0;
            rv_q  <= 1'b0;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
        MAC: begin
          if (last_k) begin
            res_q[r_off +: RW] <= sum;
            acc_q <= '0;
            k_q   <= '0;
            if (last_j) begin
              j_q <= '0;
              i_q <= last_i ? '0 : i_q + 1'b1;
              if (last_i) rv_q <= 1'b1;
            end else begin
              j_q <= j_q + 1'b1;
            end
          end else begin
            acc_q <= sum;
            k_q   <= k_q + 1'b1;
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  assign busy         = (state_q == MAC);
  assign done         = (state_q == DONE);
  assign result_valid = rv_q;
  assign result       = res_q;

endmodule

// File: tb/tb_mpu_mul_seq_ctrl.sv
// Bench for mpu_mul_seq_ctrl: matrix-level reference model plus directed
// and randomized jobs.
module tb_mpu_mul_seq_ctrl;

  localparam int N  = 5;
  localparam int DW = 8;
  localparam int RW = 16;
  localparam int AW = DW*N*N;
  localparam int OW = RW*N*N;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    size = 8'd5;
  logic [0:AW-1] matrix_a = '0;
  logic [0:AW-1] matrix_b = '0;
  logic          busy, done, result_valid;
  logic [OW-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  mpu_mul_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size),
    .matrix_a(matrix_a), .matrix_b(matrix_b),
    .busy(busy), .done(done), .result_valid(result_valid),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_n(input logic [7:0] s);
    return (s == 0 || s > 8'(N)) ? N : int'(s);
  endfunction

  function automatic logic [OW-1:0] mm(input logic [0:AW-1] a,
                                       input logic [0:AW-1] b, input int n);
    logic [OW-1:0] r;
    int s;
    r = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++)
          s += int'(a[DW*(k+N*i) +: DW]) * int'(b[DW*(j+N*k) +: DW]);
`ifdef MPU_MUL_SAT_EN
        if (s > 65535) s = 65535;
`else
        s = s % 65536;
`endif
        r[RW*(j*N+i) +: RW] = 16'(s);
      end
    return r;
  endfunction

  // Reference: job accepted in idle runs n^3 busy cycles, then one done cycle.
  initial begin
    int            left;
    logic          m_done, m_rv, s_rst, s_start;
    logic [7:0]    s_size;
    logic [0:AW-1] s_a, s_b;
    logic [OW-1:0] m_res, m_pend;
    int            n;
    left = 0; m_done = 0; m_rv = 0; m_res = '0; m_pend = '0;
    forever begin
      @(posedge clk);
      s_rst = rst_n; s_start = start; s_size = size;
      s_a = matrix_a; s_b = matrix_b;
      if (!s_rst) begin
        left = 0; m_done = 0; m_rv = 0; m_res = '0;
      end else if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1; m_rv = 1; m_res = m_pend;
        end
      end else if (m_done) begin
        m_done = 0;
      end else if (s_start) begin
        n = eff_n(s_size);
        m_pend = mm(s_a, s_b, n);
        left = n*n*n;
        m_rv = 0; m_res = '0;
      end
      #1;
      check("busy", OW'(busy), OW'(left > 0));
      check("done", OW'(done), OW'(m_done));
      check("result_valid", OW'(result_valid), OW'(m_rv));
      if (left == 0) check("result", result, m_res);
    end
  end

  function automatic logic [0:AW-1] fill(input int mode, input logic [7:0] v);
    logic [0:AW-1] m;
    m = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (mode)
          0: m[DW*(j+N*i) +: DW] = (i == j) ? 8'd1 : 8'd0;
          1: m[DW*(j+N*i) +: DW] = 8'(5*i + j + 1);
          2: m[DW*(j+N*i) +: DW] = v;
          default: m[DW*(j+N*i) +: DW] = 8'($urandom_range(0, 255));
        endcase
    return m;
  endfunction

  function automatic logic [OW-1:0] elem(input int i, input int j);
    logic [OW-1:0] r;
    r = result;
    return OW'(r[RW*(j*N+i) +: RW]);
  endfunction

  task automatic run_job(input logic [7:0] sz, input logic [0:AW-1] a,
                         input logic [0:AW-1] b, input int p1, input int p2,
                         input int rst_at, output int lat, output int bcyc);
    @(posedge clk); #1;
    size = sz; matrix_a = a; matrix_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bcyc = 0;
    forever begin
      if (busy) bcyc++;
      if (done) break;
      if (lat == rst_at + 1) begin
        rst_n = 1'b1;
        break;
      end
      if (lat == rst_at) rst_n = 1'b0;
      if (lat == p1 || lat == p2) begin
        start = 1'b1; matrix_a = ~a; matrix_b = ~b; size = 8'd1;
      end else begin
        start = 1'b0;
      end
      if (lat >= 300) begin
        check("timeout", OW'(lat), OW'(0));
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat, bc;
    logic [0:AW-1] id, a5;
    id = fill(0, 0);
    a5 = fill(1, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_result", result, '0);

    run_job(8'd5, a5, id, -1, -1, -1, lat, bc);
    check("id5_lat", OW'(lat), OW'(126));
    check("id5_busy_cycles", OW'(bc), OW'(125));
    check("id5_e23", elem(2, 3), OW'(14));
    check("id5_e44", elem(4, 4), OW'(25));

    run_job(8'd3, fill(2, 8'd1), fill(2, 8'd2), -1, -1, -1, lat, bc);
    check("sub3_lat", OW'(lat), OW'(28));
    check("sub3_e21", elem(2, 1), OW'(6));
    check("sub3_e33", elem(3, 3), OW'(0));
    check("sub3_e03", elem(0, 3), OW'(0));

    run_job(8'd5, fill(2, 8'hff), fill(2, 8'hff), -1, -1, -1, lat, bc);
`ifdef MPU_MUL_SAT_EN
    check("ovf_e00", elem(0, 0), OW'(65535));
`else
    check("ovf_e00", elem(0, 0), OW'(62981));
`endif

    run_job(8'd5, a5, id, 10, 50, -1, lat, bc);
    check("pulse_lat", OW'(lat), OW'(126));
    check("pulse_e10", elem(1, 0), OW'(6));

    run_job(8'd5, a5, id, -1, -1, 40, lat, bc);
    check("midrst_busy", OW'(busy), OW'(0));
    check("midrst_done", OW'(done), OW'(0));
    check("midrst_rv", OW'(result_valid), OW'(0));
    check("midrst_result", result, '0);
    run_job(8'd2, id, id, -1, -1, -1, lat, bc);
    check("n2_lat", OW'(lat), OW'(9));
    check("n2_e00", elem(0, 0), OW'(1));
    check("n2_e11", elem(1, 1), OW'(1));
    check("n2_e01", elem(0, 1), OW'(0));

    run_job(8'd0, a5, id, -1, -1, -1, lat, bc);
    check("sz0_lat", OW'(lat), OW'(126));
    check("sz0_e40", elem(4, 0), OW'(21));
    run_job(8'd7, a5, id, -1, -1, -1, lat, bc);
    check("sz7_lat", OW'(lat), OW'(126));
    check("sz7_e34", elem(3, 4), OW'(20));

    for (int t = 0; t < 10; t++) begin
      logic [7:0] sz;
      int n;
      sz = 8'($urandom_range(0, 7));
      n = eff_n(sz);
      run_job(sz, fill(3, 0), fill(3, 0), $urandom_range(2, 130), -1, -1,
              lat, bc);
      check("rand_lat", OW'(lat), OW'(n*n*n + 1));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
